// File: rtl/pipeline_credit_fifo.sv
// Credit-gated result FIFO behind a fixed-latency, non-stallable pipeline.
// Credits cover every issued-but-unpopped transaction, so a result can never arrive without a free slot.
module pipeline_credit_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic                  pipe_valid,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         occupancy,
    output logic [CW-1:0]         credits,
    output logic                  protocol_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          err_q, err_d;

    logic [CW-1:0] inflight;
    logic          issue_fire;
    logic          pop;
    logic          wr_accept;
    logic          wr_reject;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign issue_ready = !rst && (outst_q < CW'(DEPTH));
    assign issue_fire  = issue_valid && issue_ready;

    assign out_valid   = (occ_q != '0);
    assign out_data    = mem[rd_ptr_q];
    assign pop         = out_valid && out_ready;

    // A result is only legal if it was issued and has not landed yet; fullness uses pre-edge occupancy.
    assign inflight    = outst_q - occ_q;
    assign wr_accept   = pipe_valid && (occ_q < CW'(DEPTH)) && (inflight != '0);
    assign wr_reject   = pipe_valid && !wr_accept;

    assign occupancy    = occ_q;
    assign credits      = CW'(DEPTH) - outst_q;
    assign protocol_err = err_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        outst_d  = outst_q;
        err_d    = err_q;

        if (wr_accept) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({wr_accept, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        case ({issue_fire, pop})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase

        if (wr_reject) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left out of reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr_q] <= pipe_data;
        end
    end

endmodule
